ledr_avmm_pwm_slave: RTL and testbench
======================================

// Module: ledr_avmm_pwm_slave
// PURPOSE
//  Avalon-MM responder that the HPS lightweight bridge masters in order to drive
//  the board LEDs through ledr_export. It holds four control registers and drives
//  the LEDs either statically or with a PWM dimming waveform.
//  It sits in the FPGA fabric between the bridge interconnect and the top-level LED pins.
// PARAMETERS
//  NUM_LED  1   number of LED outputs (1..32)
//  CNT_W    16  width of the PWM period/duty counter (2..32)
// PORTS
//  clk                in   1        single fabric clock
//  reset              in   1        asynchronous, active-high reset
//  avs_address        in   2        word address, register select
//  avs_read           in   1        read request
//  avs_write          in   1        write request
//  avs_writedata      in   32       write data
//  avs_byteenable     in   4        byte lanes to write
//  avs_readdata       out  32       read data, valid with avs_readdatavalid
//  avs_readdatavalid  out  1        one-cycle pulse per accepted read
//  avs_waitrequest    out  1        held 0 (every access is accepted on the cycle it is issued)
//  ledr_export        out  NUM_LED  LED drive, registered
// BEHAVIOUR
//  Register map (word address):
//   0 CTRL   [0]=EN  [1]=MODE (0 static, 1 pwm)  [2]=INV; other bits read 0
//   1 LEVEL  [NUM_LED-1:0] LED pattern; upper bits read 0
//   2 PERIOD [CNT_W-1:0]; PWM period is PERIOD+1 clk cycles
//   3 DUTY   [CNT_W-1:0]; PWM is high while cnt < DUTY
//  Reset: all registers, cnt, shadows, avs_readdata, avs_readdatavalid and ledr_export are 0.
//  Writes:
//   - Commit on the clk edge where avs_write=1.
//   - Only the bytes with byteenable set update; bits beyond the register width are dropped.
//  Reads:
//   - avs_readdatavalid=1 exactly one cycle after the avs_read cycle, with the register value.
//   - avs_readdata holds its last value when avs_readdatavalid=0.
//   - Back-to-back reads give back-to-back valid pulses, in order.
//  Read and write in the same cycle: the write commits and the read is ignored (no readdatavalid).
//  Read in the cycle after a write to the same register returns the new value.
//  PWM counter cnt (CNT_W bits):
//   - Runs only while EN=1 and MODE=1; otherwise it is held at 0.
//   - Each cycle: cnt <= (cnt == per_s) ? 0 : cnt+1.
//  Shadows per_s and duty_s:
//   - Loaded from PERIOD and DUTY while the counter is stopped, and on the wrap cycle (cnt == per_s).
//   - A mid-period PERIOD or DUTY write therefore takes effect at the next wrap. No glitch, no overrun.
//  pwm_on = (cnt < duty_s):
//   - DUTY=0 gives always off.
//   - DUTY > PERIOD gives always on.
//   - PERIOD=0 gives cnt stuck at 0 and pwm_on = (DUTY != 0).
//  raw = MODE ? (LEVEL & {NUM_LED{pwm_on}}) : LEVEL.
//  ledr_export <= EN ? (raw ^ {NUM_LED{INV}}) : 0.
//   - Registered: one cycle after cnt and the registers.
//   - CTRL writes show on LEDs 2 cycles after the write cycle.
//  Reset asserted mid-operation clears everything immediately (async).
//   - A pending readdatavalid is dropped.
//   - After release, behaviour is identical to power-up.
// TESTING
//  1 Write CTRL=0xFFFFFFFF, be=4'b0001, then read all 4 regs -> CTRL reads 0x7, others read 0;
//    each valid comes exactly 1 cycle after its read.
//  2 NUM_LED=4: LEVEL=0xA, CTRL=0x1 -> ledr_export=4'hA; then CTRL=0x5 -> 4'h5 two cycles after that write.
//  3 LEVEL=1, PERIOD=3, DUTY=2, CTRL=0x3 -> ledr_export repeats 1,1,0,0 with a 4-cycle period.
//  4 Scenario 3, then write PERIOD=5 at cnt=1 -> the current period ends after 4 cycles,
//    then the pattern is 1,1,0,0,0,0.
//  5 DUTY=0 -> LED constant 0; DUTY=7 with PERIOD=3 -> LED constant 1; PERIOD=0, DUTY=1 -> constant 1.
//  6 Assert reset for 1 cycle mid-PWM and during a pending read -> outputs 0, no readdatavalid,
//    all regs read back 0.

Source files
------------

// File: rtl/ledr_avmm_pwm_slave.sv
// ---------------------------------------------------------------------------
// ledr_avmm_pwm_slave
//   Avalon-MM responder driving the board LEDs, either statically or with a
//   PWM dimming waveform. Four word registers: CTRL, LEVEL, PERIOD, DUTY.
//
// Parameters
//   NUM_LED  number of LED outputs (1..32)
//   CNT_W    width of the PWM period/duty counter (2..32)
//
// Ports
//   clk                fabric clock
//   reset              asynchronous, active-high reset
//   avs_address[1:0]   word address (register select)
//   avs_read           read request
//   avs_write          write request
//   avs_writedata[31:0] write data
//   avs_byteenable[3:0] byte lanes to write
//   avs_readdata[31:0] read data, valid with avs_readdatavalid
//   avs_readdatavalid  one-cycle pulse per accepted read
//   avs_waitrequest    always 0
//   ledr_export        registered LED drive
// ---------------------------------------------------------------------------
module ledr_avmm_pwm_slave #(
   parameter int unsigned NUM_LED = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         avs_address,
   input  logic               avs_read,
   input  logic               avs_write,
   input  logic [31:0]        avs_writedata,
   input  logic [3:0]         avs_byteenable,
   output logic [31:0]        avs_readdata,
   output logic               avs_readdatavalid,
   output logic               avs_waitrequest,
   output logic [NUM_LED-1:0] ledr_export
);

   logic [2:0]         r_ctrl;
   logic [NUM_LED-1:0] r_level;
   logic [CNT_W-1:0]   r_period;
   logic [CNT_W-1:0]   r_duty;

   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_per_s;
   logic [CNT_W-1:0]   r_duty_s;

   logic [31:0]        r_rdata;
   logic               r_rdv;
   logic [NUM_LED-1:0] r_led;

   logic [31:0]        w_cur;
   logic [31:0]        w_merged;
   logic               w_unused_bits;
   logic               w_run;
   logic               w_wrap;
   logic               w_pwm_on;
   logic [NUM_LED-1:0] w_raw;

   // Addressed register, zero-extended to 32 bits. Serves as both the read
   // mux and the base value for partial-byte writes.
   always_comb begin
      w_cur = '0;
      case (avs_address)
         2'd0:    w_cur[2:0]         = r_ctrl;
         2'd1:    w_cur[NUM_LED-1:0] = r_level;
         2'd2:    w_cur[CNT_W-1:0]   = r_period;
         default: w_cur[CNT_W-1:0]   = r_duty;
      endcase
   end

   always_comb begin
      w_merged = w_cur;
      for (int unsigned b = 0; b < 4; b++) begin
         if (avs_byteenable[b]) w_merged[8*b +: 8] = avs_writedata[8*b +: 8];
      end
   end

   // Bits above the register width are intentionally dropped.
   assign w_unused_bits = ^w_merged;

   // Register file and read response. A read coinciding with a write is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl   <= '0;
         r_level  <= '0;
         r_period <= '0;
         r_duty   <= '0;
         r_rdata  <= '0;
         r_rdv    <= 1'b0;
      end else begin
         r_rdv <= avs_read && !avs_write;
         if (avs_write) begin
            case (avs_address)
               2'd0:    r_ctrl   <= w_merged[2:0];
               2'd1:    r_level  <= w_merged[NUM_LED-1:0];
               2'd2:    r_period <= w_merged[CNT_W-1:0];
               default: r_duty   <= w_merged[CNT_W-1:0];
            endcase
         end else if (avs_read) begin
            r_rdata <= w_cur;
         end
      end
   end

   assign w_run  = r_ctrl[0] && r_ctrl[1];
   assign w_wrap = (r_cnt == r_per_s);

   // Shadows track PERIOD/DUTY while stopped and reload only at the wrap,
   // so mid-period writes cannot truncate or overrun the running period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_per_s  <= '0;
         r_duty_s <= '0;
      end else if (!w_run || w_wrap) begin
         r_cnt    <= '0;
         r_per_s  <= r_period;
         r_duty_s <= r_duty;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign w_pwm_on = (r_cnt < r_duty_s);
   assign w_raw    = r_ctrl[1] ? (r_level & {NUM_LED{w_pwm_on}}) : r_level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_led <= '0;
      end else begin
         r_led <= r_ctrl[0] ? (w_raw ^ {NUM_LED{r_ctrl[2]}}) : '0;
      end
   end

   assign avs_readdata      = r_rdata;
   assign avs_readdatavalid = r_rdv;
   assign avs_waitrequest   = 1'b0;
   assign ledr_export       = r_led;

endmodule

// File: tb/tb_ledr_avmm_pwm_slave.sv
// ---------------------------------------------------------------------------
// tb_ledr_avmm_pwm_slave
//   Directed scenarios plus randomized bus traffic for ledr_avmm_pwm_slave
//   (NUM_LED=4, CNT_W=16), checked against a behavioural model of the
//   register map and the PWM period/duty rules.
// ---------------------------------------------------------------------------
module tb_ledr_avmm_pwm_slave;

   localparam int unsigned NL = 4;
   localparam int unsigned CW = 16;
   localparam logic [31:0] MASK0 = 32'h7;
   localparam logic [31:0] MASK1 = (32'h1 << NL) - 32'h1;
   localparam logic [31:0] MASK2 = (32'h1 << CW) - 32'h1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    avs_address = '0;
   logic          avs_read = 1'b0;
   logic          avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic [3:0]    avs_byteenable = '0;
   logic [31:0]   avs_readdata;
   logic          avs_readdatavalid;
   logic          avs_waitrequest;
   logic [NL-1:0] ledr_export;

   int total = 0;
   int bad   = 0;
   logic [NL-1:0] last_led;

   ledr_avmm_pwm_slave #(.NUM_LED(NL), .CNT_W(CW)) dut (
      .clk               (clk),
      .reset             (reset),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_byteenable    (avs_byteenable),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .avs_waitrequest   (avs_waitrequest),
      .ledr_export       (ledr_export)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   // The PWM is modelled as a position inside a period of length PERIOD+1;
   // period length and threshold are captured whenever a new period begins.
   logic [31:0]   m_reg [4] = '{default: 32'h0};
   int unsigned   m_pos  = 0;
   int unsigned   m_plen = 1;
   int unsigned   m_thr  = 0;
   logic [NL-1:0] m_led   = '0;
   logic          m_rdv   = 1'b0;
   logic [31:0]   m_rdata = '0;
   logic          m_en, m_mode, m_inv, m_on;
   logic [NL-1:0] m_pat;
   logic [31:0]   m_mask;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < 4; r++) m_reg[r] = '0;
         m_pos = 0; m_plen = 1; m_thr = 0;
         m_led = '0; m_rdv = 1'b0; m_rdata = '0;
      end else begin
         m_en   = m_reg[0][0];
         m_mode = m_reg[0][1];
         m_inv  = m_reg[0][2];
         m_on   = (m_pos < m_thr);
         m_pat  = m_reg[1][NL-1:0];
         if (m_mode && !m_on) m_pat = '0;
         m_led  = !m_en ? '0 : (m_inv ? ~m_pat : m_pat);

         if (!(m_en && m_mode) || (m_pos + 1 >= m_plen)) begin
            m_pos  = 0;
            m_plen = m_reg[2] + 32'd1;
            m_thr  = m_reg[3];
         end else begin
            m_pos = m_pos + 1;
         end

         m_rdv = 1'b0;
         if (avs_write) begin
            case (avs_address)
               2'd0:    m_mask = MASK0;
               2'd1:    m_mask = MASK1;
               default: m_mask = MASK2;
            endcase
            for (int b = 0; b < 4; b++)
               if (avs_byteenable[b]) m_reg[avs_address][8*b +: 8] = avs_writedata[8*b +: 8];
            m_reg[avs_address] = m_reg[avs_address] & m_mask;
         end else if (avs_read) begin
            m_rdv   = 1'b1;
            m_rdata = m_reg[avs_address];
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      last_led = ledr_export;
      chk("led",     32'(ledr_export),       32'(m_led));
      chk("rdv",     32'(avs_readdatavalid), 32'(m_rdv));
      chk("rdata",   avs_readdata,           m_rdata);
      chk("waitreq", 32'(avs_waitrequest),   32'h0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      avs_address = a; avs_writedata = d; avs_byteenable = be;
      avs_write = 1'b1; avs_read = 1'b0;
      tick();
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a);
      avs_address = a; avs_read = 1'b1; avs_write = 1'b0;
      tick();
      avs_read = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int unsigned   k;
   logic [31:0]   wd;
   logic [NL-1:0] seq_exp [12] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1,
                                   4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_led",   32'(ledr_export),       32'h0);
      chk("rst_rdv",   32'(avs_readdatavalid), 32'h0);
      chk("rst_rdata", avs_readdata,           32'h0);
      reset = 1'b0;
      idle(2);

      // 1: CTRL lane-0 write keeps only the defined bits; back-to-back reads
      wr(2'd0, 32'hFFFF_FFFF, 4'b0001);
      rd(2'd0); chk("t1_ctrl", avs_readdata, 32'h7); chk("t1_v0", 32'(avs_readdatavalid), 32'h1);
      rd(2'd1); chk("t1_lvl",  avs_readdata, 32'h0); chk("t1_v1", 32'(avs_readdatavalid), 32'h1);
      rd(2'd2); chk("t1_per",  avs_readdata, 32'h0); chk("t1_v2", 32'(avs_readdatavalid), 32'h1);
      rd(2'd3); chk("t1_duty", avs_readdata, 32'h0); chk("t1_v3", 32'(avs_readdatavalid), 32'h1);
      idle(1);  chk("t1_novalid", 32'(avs_readdatavalid), 32'h0);

      // 2: static LEDs, then inversion two cycles after the CTRL write
      wr(2'd1, 32'hA, 4'hF);
      wr(2'd0, 32'h1, 4'hF);
      tick();   chk("t2_static", 32'(last_led), 32'hA);
      wr(2'd0, 32'h5, 4'hF); chk("t2_old", 32'(last_led), 32'hA);
      tick();   chk("t2_inv", 32'(last_led), 32'h5);

      // 3/4: PWM 1,1,0,0 then PERIOD=5 written while cnt=1
      wr(2'd0, 32'h0, 4'hF);
      wr(2'd1, 32'h1, 4'hF);
      wr(2'd2, 32'h3, 4'hF);
      wr(2'd3, 32'h2, 4'hF);
      wr(2'd0, 32'h3, 4'hF);
      tick();                chk("t3_seq0", 32'(last_led), 32'(seq_exp[0]));
      wr(2'd2, 32'h5, 4'hF); chk("t3_seq1", 32'(last_led), 32'(seq_exp[1]));
      for (int i = 2; i < 12; i++) begin
         tick(); chk("t4_seq", 32'(last_led), 32'(seq_exp[i]));
      end

      // 5: duty boundaries
      wr(2'd0, 32'h0, 4'hF); wr(2'd2, 32'h3, 4'hF); wr(2'd3, 32'h0, 4'hF); wr(2'd0, 32'h3, 4'hF);
      idle(2);
      for (int i = 0; i < 8; i++) begin tick(); chk("t5_duty0", 32'(last_led), 32'h0); end
      wr(2'd0, 32'h0, 4'hF); wr(2'd3, 32'h7, 4'hF); wr(2'd0, 32'h3, 4'hF);
      idle(2);
      for (int i = 0; i < 8; i++) begin tick(); chk("t5_duty7", 32'(last_led), 32'h1); end
      wr(2'd0, 32'h0, 4'hF); wr(2'd2, 32'h0, 4'hF); wr(2'd3, 32'h1, 4'hF); wr(2'd0, 32'h3, 4'hF);
      idle(2);
      for (int i = 0; i < 8; i++) begin tick(); chk("t5_per0", 32'(last_led), 32'h1); end

      // 6: reset mid-PWM with a read whose valid would be showing
      wr(2'd2, 32'h3, 4'hF);
      idle(3);
      avs_address = 2'd2; avs_read = 1'b1;
      @(posedge clk);
      #1 reset = 1'b1;
      avs_read = 1'b0;
      @(negedge clk);
      chk("t6_led",   32'(ledr_export),       32'h0);
      chk("t6_rdv",   32'(avs_readdatavalid), 32'h0);
      chk("t6_rdata", avs_readdata,           32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rd(2'd0); chk("t6_r0", avs_readdata, 32'h0);
      rd(2'd1); chk("t6_r1", avs_readdata, 32'h0);
      rd(2'd2); chk("t6_r2", avs_readdata, 32'h0);
      rd(2'd3); chk("t6_r3", avs_readdata, 32'h0);
      idle(3);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         k  = $urandom_range(0, 9);
         wd = $urandom;
         avs_address = 2'($urandom_range(0, 3));
         if (avs_address >= 2'd2 && $urandom_range(0, 3) != 0) wd = wd & 32'h7;
         if (avs_address == 2'd0 && $urandom_range(0, 1) != 0) wd = wd | 32'h3;
         avs_writedata  = wd;
         avs_byteenable = 4'($urandom);
         avs_write = (k < 3);
         avs_read  = (k >= 2 && k < 7);
         tick();
      end
      avs_write = 1'b0; avs_read = 1'b0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
